// File: rtl/ddep_chk_if.sv
// ddep_chk_if: decode-side handshake between the decoder/controller and the dependency checker.
interface ddep_chk_if #(
   parameter int AW = 5
);
   logic          dec_valid_i;
   logic          rs1_re_i;
   logic [AW-1:0] rs1_addr_i;
   logic          rs2_re_i;
   logic [AW-1:0] rs2_addr_i;
   logic          rd_we_i;
   logic [AW-1:0] rd_addr_i;
   logic [1:0]    lat_class_i;
   logic          stall_dec_i;
   logic          flush_i;
   logic          ddep_conflict_o;
   logic          busy_o;

   modport master (
      output dec_valid_i, rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i,
             rd_we_i, rd_addr_i, lat_class_i, stall_dec_i, flush_i,
      input  ddep_conflict_o, busy_o
   );

   modport slave (
      input  dec_valid_i, rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i,
             rd_we_i, rd_addr_i, lat_class_i, stall_dec_i, flush_i,
      output ddep_conflict_o, busy_o
   );
endinterface

// File: rtl/ddep_chk.sv
// ddep_chk: register scoreboard; per-register countdowns until a result is forwardable,
// raising a same-cycle stall request on RAW/WAW hazards against pending destinations.
module ddep_chk #(
   parameter int NREG    = 32,
   parameter int AW      = 5,
   parameter int LAT_W   = 3,
   parameter int ALU_LAT = 0,
   parameter int LD_LAT  = 1,
   parameter int MUL_LAT = 3
) (
   input logic       clk,
   input logic       rst_n,
   ddep_chk_if.slave bus
);
   logic [LAT_W-1:0] cnt_q [1:NREG-1];
   logic [LAT_W-1:0] cnt_d [1:NREG-1];
   logic [NREG-1:0]  pend;
   logic [LAT_W-1:0] lat_sel;
   logic             issue;

   // r0 has no entry, so its pending bit stays 0 and it never conflicts
   always_comb begin
      pend = '0;
      for (int r = 1; r < NREG; r++) pend[r] = |cnt_q[r];
   end

   assign issue   = bus.dec_valid_i & ~bus.stall_dec_i & ~bus.flush_i;
   assign lat_sel = (bus.lat_class_i == 2'b00) ? LAT_W'(ALU_LAT) :
                    (bus.lat_class_i == 2'b01) ? LAT_W'(LD_LAT)  : LAT_W'(MUL_LAT);

   assign bus.ddep_conflict_o = bus.dec_valid_i & (
      (bus.rs1_re_i & pend[bus.rs1_addr_i]) |
      (bus.rs2_re_i & pend[bus.rs2_addr_i]) |
      (bus.rd_we_i  & pend[bus.rd_addr_i]));
   assign bus.busy_o = |pend;

   // a new issue to the same register overrides that entry's decrement
   always_comb begin
      for (int r = 1; r < NREG; r++)
         cnt_d[r] = bus.flush_i ? '0 :
                    (issue & bus.rd_we_i & (bus.rd_addr_i == AW'(r))) ? lat_sel :
                    (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      end
   end
endmodule

// File: tb/tb_ddep_chk.sv
// tb_ddep_chk: directed stimulus; a ready-time model checks every cycle, literal
// expectations pin the model on the scenarios of interest.
module tb_ddep_chk;
   localparam int NREG    = 32;
   localparam int AW      = 5;
   localparam int LAT_W   = 3;
   localparam int ALU_LAT = 0;
   localparam int LD_LAT  = 1;
   localparam int MUL_LAT = 3;

   if (ALU_LAT >= (1 << LAT_W) || LD_LAT >= (1 << LAT_W) || MUL_LAT >= (1 << LAT_W)) begin : g_lat_bad
      initial $fatal(1, "latency parameter does not fit in LAT_W");
   end

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   ddep_chk_if #(.AW(AW)) bus ();

   ddep_chk #(
      .NREG(NREG), .AW(AW), .LAT_W(LAT_W),
      .ALU_LAT(ALU_LAT), .LD_LAT(LD_LAT), .MUL_LAT(MUL_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // model: absolute cycle at which each register's result becomes usable
   longint now = 0;
   longint ready_at [NREG];

   function automatic int lat_of(input logic [1:0] c);
      return (c == 2'd0) ? ALU_LAT : (c == 2'd1) ? LD_LAT : MUL_LAT;
   endfunction

   function automatic bit waiting(input int r);
      return r != 0 && ready_at[r] > now;
   endfunction

   function automatic bit exp_conflict();
      return bus.dec_valid_i && (
         (bus.rs1_re_i && waiting(int'(bus.rs1_addr_i))) ||
         (bus.rs2_re_i && waiting(int'(bus.rs2_addr_i))) ||
         (bus.rd_we_i  && waiting(int'(bus.rd_addr_i))));
   endfunction

   function automatic bit exp_busy();
      bit b = 0;
      for (int r = 1; r < NREG; r++) if (ready_at[r] > now) b = 1;
      return b;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      end else begin
         if (bus.flush_i) begin
            for (int r = 0; r < NREG; r++) ready_at[r] = 0;
         end else if (bus.dec_valid_i && !bus.stall_dec_i && bus.rd_we_i && bus.rd_addr_i != 0) begin
            ready_at[bus.rd_addr_i] = now + lat_of(bus.lat_class_i) + 1;
         end
      end
      if (rst_n) now = now + 1;
   end

   always @(negedge clk) begin
      bit ec, eb;
      ec = exp_conflict();
      eb = exp_busy();
      n_cmp++;
      if (bus.ddep_conflict_o !== ec) begin
         n_bad++;
         $display("FAIL model_conflict t=%0t got=%b want=%b", $time, bus.ddep_conflict_o, ec);
      end
      n_cmp++;
      if (bus.busy_o !== eb) begin
         n_bad++;
         $display("FAIL model_busy t=%0t got=%b want=%b", $time, bus.busy_o, eb);
      end
   end

   task automatic chk(input string nm, input logic ec, input logic eb);
      n_cmp++;
      if (bus.ddep_conflict_o !== ec) begin
         n_bad++;
         $display("FAIL %s conflict got=%b want=%b", nm, bus.ddep_conflict_o, ec);
      end
      n_cmp++;
      if (bus.busy_o !== eb) begin
         n_bad++;
         $display("FAIL %s busy got=%b want=%b", nm, bus.busy_o, eb);
      end
   endtask

   // v, rs1_re, rs1, rs2_re, rs2, rd_we, rd, class, stall, flush
   task automatic drv(input logic v, input logic r1e, input int r1, input logic r2e, input int r2,
                      input logic we, input int rd, input logic [1:0] cls, input logic st, input logic fl);
      bus.dec_valid_i = v;
      bus.rs1_re_i    = r1e;
      bus.rs1_addr_i  = AW'(r1);
      bus.rs2_re_i    = r2e;
      bus.rs2_addr_i  = AW'(r2);
      bus.rd_we_i     = we;
      bus.rd_addr_i   = AW'(rd);
      bus.lat_class_i = cls;
      bus.stall_dec_i = st;
      bus.flush_i     = fl;
   endtask

   // check mid-cycle, then move to just after the next rising edge
   task automatic cyc(input string nm, input logic ec, input logic eb);
      @(negedge clk);
      chk(nm, ec, eb);
      @(posedge clk);
      #1;
   endtask

   initial begin
      drv(1, 1, 3, 1, 4, 0, 0, 2'd0, 0, 0);
      #1;
      cyc("reset0", 0, 0);
      cyc("reset1", 0, 0);
      rst_n = 1'b1;
      cyc("idle", 0, 0);

      // load-use
      drv(1, 0, 0, 0, 0, 1, 5, 2'd1, 0, 0); cyc("ld_issue", 0, 0);
      drv(1, 1, 5, 0, 0, 0, 0, 2'd0, 1, 0); cyc("ld_use_t1", 1, 1);
      drv(1, 1, 5, 0, 0, 0, 0, 2'd0, 0, 0); cyc("ld_use_t2", 0, 0);

      // mul chain, consumer on rs2
      drv(1, 0, 0, 0, 0, 1, 7, 2'd2, 0, 0); cyc("mul_issue", 0, 0);
      drv(1, 0, 0, 1, 7, 0, 0, 2'd0, 1, 0); cyc("mul_t1", 1, 1);
      cyc("mul_t2", 1, 1);
      cyc("mul_t3", 1, 1);
      drv(1, 0, 0, 1, 7, 0, 0, 2'd0, 0, 0); cyc("mul_t4", 0, 0);
      drv(1, 0, 0, 0, 0, 1, 8, 2'd0, 0, 0); cyc("alu_wr", 0, 0);
      drv(1, 1, 8, 0, 0, 0, 0, 2'd0, 0, 0); cyc("alu_rd", 0, 0);

      // WAW on r9
      drv(1, 0, 0, 0, 0, 1, 9, 2'd2, 0, 0); cyc("waw_mul", 0, 0);
      drv(1, 0, 0, 0, 0, 1, 9, 2'd0, 1, 0); cyc("waw_t1", 1, 1);
      cyc("waw_t2", 1, 1);
      cyc("waw_t3", 1, 1);
      drv(1, 0, 0, 0, 0, 1, 9, 2'd0, 0, 0); cyc("waw_t4", 0, 0);

      // r0 never tracked
      drv(1, 0, 0, 0, 0, 1, 0, 2'd1, 0, 0); cyc("r0_ld", 0, 0);
      drv(1, 1, 0, 1, 0, 1, 0, 2'd2, 0, 0); cyc("r0_rd", 0, 0);

      // stall gating: entry set only on the unstalled cycle
      drv(1, 0, 0, 0, 0, 1, 6, 2'd1, 1, 0); cyc("stg_a", 0, 0);
      cyc("stg_b", 0, 0);
      drv(1, 0, 0, 0, 0, 1, 6, 2'd1, 0, 0); cyc("stg_c", 0, 0);
      drv(1, 1, 6, 0, 0, 0, 0, 2'd0, 1, 0); cyc("stg_d", 1, 1);
      drv(1, 1, 6, 0, 0, 0, 0, 2'd0, 0, 0); cyc("stg_e", 0, 0);

      // flush with a simultaneous (discarded) issue to r11
      drv(1, 0, 0, 0, 0, 1, 10, 2'd2, 0, 0); cyc("fl_issue", 0, 0);
      drv(1, 1, 10, 0, 0, 1, 11, 2'd2, 0, 1); cyc("fl_cycle", 1, 1);
      drv(1, 1, 10, 1, 11, 0, 0, 2'd0, 0, 0); cyc("fl_after", 0, 0);

      // class 11 behaves as mul
      drv(1, 0, 0, 0, 0, 1, 12, 2'd3, 0, 0); cyc("c3_issue", 0, 0);
      drv(1, 1, 12, 0, 0, 0, 0, 2'd0, 1, 0); cyc("c3_t1", 1, 1);
      cyc("c3_t2", 1, 1);
      cyc("c3_t3", 1, 1);
      drv(1, 1, 12, 0, 0, 0, 0, 2'd0, 0, 0); cyc("c3_t4", 0, 0);

      // invalid decode never conflicts
      drv(1, 0, 0, 0, 0, 1, 14, 2'd1, 0, 0); cyc("inv_issue", 0, 0);
      drv(0, 1, 14, 1, 14, 1, 14, 2'd0, 0, 0); cyc("inv_rd", 0, 1);

      // asynchronous reset mid-operation
      drv(1, 0, 0, 0, 0, 1, 13, 2'd2, 0, 0); cyc("ar_issue", 0, 0);
      drv(1, 1, 13, 0, 0, 0, 0, 2'd0, 1, 0);
      #1;
      chk("ar_pending", 1, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_cleared", 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("ar_after", 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0); cyc("final", 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ddep_chk.md
Name: ddep_chk

Overview:
- Data-dependency checker (register scoreboard) in the decode stage.
- Tracks in-flight destination registers and how many cycles remain until each result can be forwarded to decode.
- Drives the data-conflict stall request consumed by the pipeline controller.
- Records an instruction's destination only when that instruction actually issues out of decode.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register address width; NREG must equal 2**AW.
- LAT_W, 3, width of each per-register countdown.
- ALU_LAT, 0, bubbles before an ALU result is forwardable; 0 means never tracked.
- LD_LAT, 1, bubbles before a load result is forwardable.
- MUL_LAT, 3, bubbles before a multiply result is forwardable.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- dec_valid_i  in  1  decode holds a valid instruction
- rs1_re_i  in  1  instruction reads rs1
- rs1_addr_i  in  AW  rs1 address
- rs2_re_i  in  1  instruction reads rs2
- rs2_addr_i  in  AW  rs2 address
- rd_we_i  in  1  instruction writes rd
- rd_addr_i  in  AW  rd address
- lat_class_i  in  2  result class: 00 ALU, 01 load, 10 mul, 11 treated as mul
- stall_dec_i  in  1  decode stalled this cycle (from pipeline controller)
- flush_i  in  1  pipeline flush; discard all pending state
- ddep_conflict_o  out  1  stall request: operand or destination not ready
- busy_o  out  1  at least one register pending

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- State: cnt[r], LAT_W bits, for r = 1..NREG-1. No storage for r0.
- Reset: every cnt = 0. Hence busy_o = 0 and ddep_conflict_o = 0 during and after reset until an issue occurs.
- ddep_conflict_o is combinational from current state and inputs; the stall must act in the same cycle. It is 1 iff dec_valid_i and any of:
  - rs1_re_i, rs1_addr_i != 0, cnt[rs1_addr_i] != 0
  - rs2_re_i, rs2_addr_i != 0, cnt[rs2_addr_i] != 0
  - rd_we_i, rd_addr_i != 0, cnt[rd_addr_i] != 0 (WAW: results must never complete out of order)
- flush_i does not mask ddep_conflict_o.
- busy_o = OR of all cnt != 0. Derived from registered state only.
- issue = dec_valid_i & !stall_dec_i & !flush_i.
- Per-cycle update, in priority order:
  - flush_i = 1: all cnt <= 0 at the next edge.
  - Otherwise, every cnt != 0 decrements by 1.
  - Then, if issue & rd_we_i & rd_addr_i != 0: cnt[rd_addr_i] <= LAT(lat_class_i). This overrides the decrement of that entry.
  - LAT(class) is ALU_LAT, LD_LAT or MUL_LAT; writing 0 leaves the entry idle.
- cnt saturates at 0. It never wraps below 0.
- All latency parameters must be < 2**LAT_W. The bench checks this at elaboration.
- Reads of r0 and writes to r0 never conflict and never set state.
- Timing: an instruction issued in cycle t with latency L makes its dependent conflict in cycles t+1..t+L; the dependent issues in t+L+1.
- Reset asserted mid-operation clears all pending state immediately (asynchronous).

Test Plan:
- Reset and idle: rst_n low, then dec_valid_i = 1 reading r3/r4 -> ddep_conflict_o = 0 and busy_o = 0 in every cycle.
- Load-use: issue load to r5 at t; next instruction reads r5 -> ddep_conflict_o = 1 at t+1, 0 at t+2; busy_o = 1 only at t+1.
- Mul chain: mul to r7 at t, consumer reads r7 on rs2 -> conflict at t+1..t+3, issues at t+4; ALU writer to r8 followed by reader of r8 -> no conflict.
- WAW and r0: mul to r9, then ALU write to r9 -> conflict 3 cycles; load to r0 followed by a reader of r0 -> no conflict, busy_o stays 0.
- Stall gating: load to r6 presented with stall_dec_i = 1 for 2 cycles, then stall_dec_i = 0 -> cnt[r6] is set only on the unstalled cycle; the dependent conflicts exactly 1 cycle after that.
- Flush: mul to r10 at t, flush_i = 1 at t+1 (conflict still 1 that cycle) -> at t+2 conflict = 0 and busy_o = 0; a simultaneous issue in the flush cycle is not recorded.
